// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the DMG timer block: IO addresses, TAC tap
// selection and the TIMA overflow/reload sequence states.
package gb_timer_pkg;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;
  localparam logic [15:0] ADDR_IF   = 16'hFF0F;

  // Register offsets relative to the block base address.
  typedef enum logic [1:0] {
    OFF_DIV  = 2'd0,
    OFF_TIMA = 2'd1,
    OFF_TMA  = 2'd2,
    OFF_TAC  = 2'd3
  } reg_off_t;

  // TAC[1:0]: which sys_cnt bit clocks TIMA.
  typedef enum logic [1:0] {
    TAC_BIT9 = 2'b00,
    TAC_BIT3 = 2'b01,
    TAC_BIT5 = 2'b10,
    TAC_BIT7 = 2'b11
  } tac_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } timer_state_t;

  function automatic logic [3:0] tap_index(input tac_sel_t sel);
    case (sel)
      TAC_BIT9: return 4'd9;
      TAC_BIT3: return 4'd3;
      TAC_BIT5: return 4'd5;
      default:  return 4'd7;
    endcase
  endfunction

  // Unused TAC bits always read back as ones.
  function automatic logic [7:0] tac_read(input logic [2:0] tac);
    return {5'b11111, tac};
  endfunction

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side bus bundle for the timer: address/write-data/strobe in, read data,
// decode hit and interrupt pulse out.
interface gb_timer_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        write;
  logic [7:0]  rdata;
  logic        hit;
  logic        irq;

  modport master (output addr, wdata, write, input rdata, hit, irq);
  modport slave  (input addr, wdata, write, output rdata, hit, irq);
endinterface

// File: rtl/gb_timer.sv
// DMG timer: free-running divider (DIV), programmable counter (TIMA) with a
// one-cycle delayed TMA reload, and a one-clk interrupt pulse on reload.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int          CNT_STEP  = 4,
  parameter logic [15:0] BASE_ADDR = ADDR_DIV
) (
  input  logic   clk,
  input  logic   rst,
  gb_timer_if.slave bus
);

  localparam logic [15:0] STEP = 16'(CNT_STEP);

  logic [15:0]  sys_cnt, sys_cnt_next;
  logic [7:0]   tima, tima_next;
  logic [7:0]   tma, tma_next;
  logic [2:0]   tac, tac_next;
  logic         tick_prev;
  timer_state_t state, state_next;

  logic [15:0]  offset;
  logic         hit;
  reg_off_t     sel;
  logic         wr_div, wr_tima, wr_tma, wr_tac;
  logic         tick_now, inc;
  logic [7:0]   tima_inc;
  logic         tima_wrap;

  // Address decode and write strobes.
  // NOTE: every signal driven from always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    offset  = bus.addr - BASE_ADDR;
    hit     = (offset[15:2] == 14'd0);
    sel     = reg_off_t'(offset[1:0]);
    wr_div  = 1'b0;
    wr_tima = 1'b0;
    wr_tma  = 1'b0;
    wr_tac  = 1'b0;
    if (bus.write && hit) begin
      case (sel)
        OFF_DIV:  wr_div  = 1'b1;
        OFF_TIMA: wr_tima = 1'b1;
        OFF_TMA:  wr_tma  = 1'b1;
        default:  wr_tac  = 1'b1;
      endcase
    end
  end

  // Falling edge of (selected bit & enable); glitches from DIV writes or TAC
  // changes are deliberately counted, as on the original silicon.
  assign tick_now  = sys_cnt[tap_index(tac_sel_t'(tac[1:0]))] & tac[2];
  assign inc       = tick_prev & ~tick_now;
  assign tima_inc  = tima + 8'd1;
  assign tima_wrap = inc && (tima == 8'hFF);

  always_comb begin
    sys_cnt_next = wr_div ? 16'd0 : sys_cnt + STEP;
    tac_next     = wr_tac ? bus.wdata[2:0] : tac;
    tma_next     = wr_tma ? bus.wdata : tma;
    tima_next    = tima;
    state_next   = state;
    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_next = bus.wdata;
        end else if (inc) begin
          tima_next = tima_inc;
          if (tima_wrap) state_next = OVF;
        end
      end
      OVF: begin
        // A CPU write to TIMA here cancels the pending reload and irq.
        if (wr_tima) begin
          tima_next  = bus.wdata;
          state_next = IDLE;
        end else begin
          tima_next  = tma_next;
          state_next = RELOAD;
        end
      end
      RELOAD: begin
        // TIMA writes are dropped; a TMA write lands in TIMA too.
        state_next = IDLE;
        if (wr_tma) begin
          tima_next = bus.wdata;
        end else if (inc) begin
          tima_next = tima_inc;
          if (tima_wrap) state_next = OVF;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_cnt   <= 16'd0;
      tima      <= 8'd0;
      tma       <= 8'd0;
      tac       <= 3'd0;
      tick_prev <= 1'b0;
      state     <= IDLE;
    end else begin
      sys_cnt   <= sys_cnt_next;
      tima      <= tima_next;
      tma       <= tma_next;
      tac       <= tac_next;
      tick_prev <= tick_now;
      state     <= state_next;
    end
  end

  always_comb begin
    bus.rdata = 8'hFF;
    if (hit) begin
      case (sel)
        OFF_DIV:  bus.rdata = sys_cnt[15:8];
        OFF_TIMA: bus.rdata = tima;
        OFF_TMA:  bus.rdata = tma;
        default:  bus.rdata = tac_read(tac);
      endcase
    end
  end

  assign bus.hit = hit;
  assign bus.irq = (state == RELOAD);

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer: directed scenarios plus a randomized run,
// all compared against a cycle-level arithmetic model of the timer rules.
module tb_gb_timer;
  import gb_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  gb_timer_if bus();

  gb_timer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers; m_age = -1 no overflow pending,
  // 0 = the cycle TIMA sits at 00, 1 = the reload/irq cycle.
  localparam int TAPS[4] = '{9, 3, 5, 7};
  int m_cnt, m_tima, m_tma, m_tac, m_age;
  bit m_prev;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_and();
    return ((m_tac >> 2) & 1) != 0 && ((m_cnt >> TAPS[m_tac & 3]) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_age = -1; m_prev = 0;
  endtask

  task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input bit w);
    bit hw, w_div, w_tima, w_tma, w_tac, now, fell;
    int bumped;
    hw     = w && a >= ADDR_DIV && a <= ADDR_TAC;
    w_div  = hw && a == ADDR_DIV;
    w_tima = hw && a == ADDR_TIMA;
    w_tma  = hw && a == ADDR_TMA;
    w_tac  = hw && a == ADDR_TAC;
    now    = m_and();
    fell   = m_prev && !now;
    m_prev = now;
    m_cnt  = w_div ? 0 : (m_cnt + 4) % 65536;
    if (w_tac) m_tac = int'(d) & 7;
    if (w_tma) m_tma = int'(d);
    bumped = m_tima + (fell ? 1 : 0);
    if (m_age == 0) begin
      if (w_tima) begin m_tima = int'(d); m_age = -1; end
      else begin m_tima = m_tma; m_age = 1; end
    end else if (m_age == 1) begin
      m_age = -1;
      if (w_tma) m_tima = int'(d);
      else if (bumped == 256) begin m_tima = 0; m_age = 0; end
      else m_tima = bumped;
    end else begin
      if (w_tima) m_tima = int'(d);
      else if (bumped == 256) begin m_tima = 0; m_age = 0; end
      else m_tima = bumped;
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    case (a)
      ADDR_DIV:  return 8'(m_cnt >> 8);
      ADDR_TIMA: return 8'(m_tima);
      ADDR_TMA:  return 8'(m_tma);
      default:   return 8'(8'hF8 | m_tac);
    endcase
  endfunction

  task automatic cycle(input logic [15:0] a, input logic [7:0] d, input bit w);
    bus.addr  = a;
    bus.wdata = d;
    bus.write = w;
    model_edge(a, d, w);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v, output logic h);
    bus.addr = a;
    #1;
    v = bus.rdata;
    h = bus.hit;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cycle(a, d, 1'b1);
  endtask

  // Idle cycle followed by TIMA and irq comparison against the model.
  task automatic idle_chk(output logic [7:0] v, output logic irq_seen);
    logic h;
    cycle(ADDR_TIMA, 8'h00, 1'b0);
    rd(ADDR_TIMA, v, h);
    irq_seen = bus.irq;
    check("tima_model", v, 16'(m_tima));
    check("irq_model", irq_seen, m_age == 1);
  endtask

  // Cycles between two successive changes of a register (-1 if bound expires).
  task automatic measure(input logic [15:0] a, input int bound, output int gap);
    logic [7:0] last, v;
    logic h;
    int first;
    first = -1;
    gap   = -1;
    rd(a, last, h);
    for (int i = 0; i < bound; i++) begin
      cycle(a, 8'h00, 1'b0);
      rd(a, v, h);
      check("meas_model", v, model_rd(a));
      if (v !== last) begin
        if (first < 0) first = i;
        else begin gap = i - first; break; end
        last = v;
      end
    end
  endtask

  task automatic setup_ovf(input logic [7:0] tma_v, input logic [7:0] tima_v);
    wr(ADDR_TAC, 8'h05);
    wr(ADDR_TMA, tma_v);
    wr(ADDR_TIMA, tima_v);
  endtask

  initial begin
    logic [7:0] v;
    logic h, irq_seen, found;
    int gap, zero_at, zero_n, irq_at, irq_n, t0;
    logic [15:0] ra;
    logic [7:0] d;
    int r;

    bus.addr = ADDR_DIV; bus.wdata = 8'h00; bus.write = 1'b0;
    model_reset();

    // Reset state, read while reset is held.
    #15;
    rd(ADDR_DIV, v, h);  check("rst_div", v, 16'h00);
    rd(ADDR_TIMA, v, h); check("rst_tima", v, 16'h00);
    rd(ADDR_TMA, v, h);  check("rst_tma", v, 16'h00);
    rd(ADDR_TAC, v, h);  check("rst_tac", v, 16'hF8);
    check("rst_irq", bus.irq, 1'b0);
    rd(16'hFF03, v, h);  check("hit_ff03", h, 1'b0);
    rd(16'hFF04, v, h);  check("hit_ff04", h, 1'b1);
    rd(16'hFF07, v, h);  check("hit_ff07", h, 1'b1);
    rd(16'hFF08, v, h);  check("hit_ff08", h, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Increment rates.
    wr(ADDR_TAC, 8'h05);
    wr(ADDR_TIMA, 8'h00);
    measure(ADDR_TIMA, 40, gap);   check("tima_rate_tac05", 16'(gap), 16'd4);
    measure(ADDR_DIV, 200, gap);   check("div_rate", 16'(gap), 16'd64);
    wr(ADDR_TAC, 8'h04);
    measure(ADDR_TIMA, 700, gap);  check("tima_rate_tac04", 16'(gap), 16'd256);

    // Overflow with reload and a single irq pulse.
    setup_ovf(8'h80, 8'hFE);
    zero_at = -1; zero_n = 0; irq_at = -1; irq_n = 0;
    for (int i = 0; i < 40; i++) begin
      idle_chk(v, irq_seen);
      if (zero_at >= 0 && i == zero_at + 1) check("reload_val", v, 16'h80);
      if (v == 8'h00) begin zero_n++; if (zero_at < 0) zero_at = i; end
      if (irq_seen) begin irq_n++; irq_at = i; end
    end
    check("ovf_zero_cycles", 16'(zero_n), 16'd1);
    check("ovf_irq_cycles", 16'(irq_n), 16'd1);
    check("ovf_irq_latency", 16'(irq_at - zero_at), 16'd1);

    // TIMA write during the 00 cycle cancels reload and irq.
    setup_ovf(8'h80, 8'hFE);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle_chk(v, irq_seen);
      if (v == 8'h00) begin found = 1'b1; break; end
    end
    check("cancel_found_ovf", found, 1'b1);
    wr(ADDR_TIMA, 8'h33);
    rd(ADDR_TIMA, v, h); check("cancel_tima", v, 16'h33);
    irq_n = 0;
    for (int i = 0; i < 12; i++) begin
      idle_chk(v, irq_seen);
      if (irq_seen) irq_n++;
    end
    check("cancel_no_irq", 16'(irq_n), 16'd0);

    // DIV write while the selected bit is high yields one extra increment.
    wr(ADDR_TIMA, 8'h10);
    for (int i = 0; i < 8; i++) begin
      if (((m_cnt >> 2) & 3) == 2) break;
      idle_chk(v, irq_seen);
    end
    check("div_bit3_phase", 16'((m_cnt >> 2) & 3), 16'd2);
    t0 = m_tima;
    wr(ADDR_DIV, 8'h5A);
    rd(ADDR_DIV, v, h);  check("div_cleared", v, 16'h00);
    rd(ADDR_TIMA, v, h); check("div_tima_hold", v, 16'(t0));
    idle_chk(v, irq_seen);
    check("div_tima_bump", v, 16'((t0 + 1) % 256));

    // TMA write during the reload cycle also lands in TIMA.
    setup_ovf(8'h80, 8'hFE);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle_chk(v, irq_seen);
      if (irq_seen) begin found = 1'b1; break; end
    end
    check("reload_found_irq", found, 1'b1);
    wr(ADDR_TMA, 8'h42);
    rd(ADDR_TIMA, v, h); check("reload_tma_tima", v, 16'h42);
    rd(ADDR_TMA, v, h);  check("reload_tma_tma", v, 16'h42);
    check("reload_irq_done", bus.irq, 1'b0);

    // Asynchronous reset while overflow is pending.
    setup_ovf(8'h80, 8'hFE);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle_chk(v, irq_seen);
      if (v == 8'h00) begin found = 1'b1; break; end
    end
    check("rstovf_found", found, 1'b1);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("rstovf_irq_async", bus.irq, 1'b0);
    @(posedge clk);
    #1;
    check("rstovf_irq_edge", bus.irq, 1'b0);
    rd(ADDR_TIMA, v, h); check("rstovf_tima", v, 16'h00);
    rd(ADDR_TAC, v, h);  check("rstovf_tac", v, 16'hF8);
    @(negedge clk);
    rst = 1'b0;
    irq_n = 0;
    for (int i = 0; i < 6; i++) begin
      idle_chk(v, irq_seen);
      if (irq_seen) irq_n++;
    end
    check("rstovf_no_irq", 16'(irq_n), 16'd0);

    // Randomized traffic against the model.
    wr(ADDR_TAC, 8'h05);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      d = 8'($urandom);
      case (r)
        0:       wr(ADDR_DIV, d);
        1:       wr(ADDR_TAC, d | 8'h04);
        2:       wr(ADDR_TAC, d);
        3:       wr(ADDR_TMA, 8'hFF);
        4:       wr(ADDR_TMA, d);
        5:       wr(ADDR_TIMA, 8'hFC | (d & 8'h03));
        6:       wr(ADDR_TIMA, d);
        default: cycle(ADDR_IF, d, 1'b0);
      endcase
      ra = 16'hFF00 + 16'($urandom_range(0, 15));
      rd(ra, v, h);
      check("rand_hit", h, (ra >= ADDR_DIV && ra <= ADDR_TAC));
      if (ra >= ADDR_DIV && ra <= ADDR_TAC) check("rand_rdata", v, model_rd(ra));
      check("rand_irq", bus.irq, m_age == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
